sw_debounce: RTL and testbench
==============================

# sw_debounce

Four-channel switch conditioner that sits directly upstream of the combination-lock FSM on the icestick board. It synchronises the raw `SW1`..`SW4` pins into `clk`, filters contact bounce with a per-channel settle counter, and produces clean levels plus single-cycle press/release strobes. The lock consumes these in place of raw pins, so it no longer needs its own edge detection.

## Interface
Parameters:
- `N_SW`, 4, number of switch channels.
- `CNT_W`, 16, settle-counter width.
- `SETTLE`, 12000, cycles a new level must hold before it is accepted (1 ms at 12 MHz). Legal range is 2 ≤ `SETTLE` < 2^`CNT_W`.

Ports:
- `clk`  in  1  system clock; all logic is on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sw_raw`  in  `N_SW`  raw asynchronous switch pins; bit 0 is `SW1`.
- `sw_level`  out  `N_SW`  debounced, registered level.
- `sw_press`  out  `N_SW`  one-cycle strobe on a debounced 0→1 transition.
- `sw_release`  out  `N_SW`  one-cycle strobe on a debounced 1→0 transition (see Configuration).

## Operation
- Every channel is independent and identical. No cross-channel priority and no coupling between channels.
- Synchroniser: two flops, `s1 <= sw_raw[i]` then `s2 <= s1`. Both reset to 0.
- Per-channel state: `level` (reset 0) and `cnt` of `CNT_W` bits (reset 0). There are two implicit states: STABLE (`s2 == level`) and SETTLING (`s2 != level`).
- On each edge:
  - If `s2 == level`: `cnt <= 0` and there are no strobes.
  - If `s2 != level` and `cnt == SETTLE-1`: `level <= s2`, `cnt <= 0`, and fire a strobe. `sw_press` fires if `s2` is 1; `sw_release` fires if `s2` is 0.
  - Otherwise: `cnt <= cnt+1`.
- Glitch rejection: if the input returns to `level` before the count completes, `cnt` clears. A later mismatch restarts counting from 0, with no partial credit.
- Strobes are registered and high for exactly one cycle. They coincide with the cycle in which `sw_level` first shows the new value.
- Counter wrap: never occurs, because `cnt` is cleared at `SETTLE-1`.
- Reset behaviour:
  - All outputs reset to 0: `sw_level`, `sw_press` and `sw_release`.
  - Asserting reset mid-settle clears `cnt` and the synchronisers immediately.
  - After release, a switch already held high is accepted as a press once the full settle latency has elapsed.

## Timing
- Edge 0 is the first posedge that samples a new raw value into `s1`.
- `s2` updates at edge 1. Counting starts at edge 2.
- `sw_level` and the strobe update at edge `SETTLE+1` and are visible for the cycle that follows.
- A raw pulse must be stable for at least `SETTLE` consecutive `s2` samples to be accepted. Anything shorter produces no output activity.
- There are no combinational paths from input to output.

## Configuration
- `SW_DEBOUNCE_RELEASE_EN` defined: `sw_release` is generated as described in Operation.
- `SW_DEBOUNCE_RELEASE_EN` undefined: the `sw_release` port remains and is tied to 0, and the release-strobe flops are not built. `sw_level` and `sw_press` are unaffected.

## Structure
- Shared package `sw_pkg`:
  - `SW_N` (4).
  - `SW_SETTLE_DEFAULT` (12000).
  - `SW_CNT_W` (16).
  - Channel index constants `SW1_IDX`..`SW4_IDX`, used by the downstream lock.
- Sub-module `sw_debounce_chan`: one channel containing the synchroniser, counter, level and strobes. The top level instantiates it `N_SW` times in a generate loop and concatenates the outputs.

## Test plan
Bench uses `SETTLE`=4 and `SW_DEBOUNCE_RELEASE_EN` defined.
- Reset: hold `rst_n`=0 with `sw_raw`=4'hF, then release. All outputs are 0 at release. `sw_level`=4'hF and `sw_press`=4'hF (one cycle) occur at edge 5 after the first sampling edge.
- Clean press on `SW1`: `sw_raw[0]` goes 0→1 and is held. `sw_level[0]` rises at edge 5. `sw_press[0]` is high for exactly that one cycle. Other bits are unchanged.
- Bounce rejection:
  - `sw_raw[2]` toggles 1,0,1,0 on consecutive cycles and then stays 0: no strobes and `sw_level[2]` stays 0.
  - A 3-cycle high pulse (below `SETTLE`) produces no activity.
- Release: from `sw_level[1]`=1, drive `sw_raw[1]`=0. `sw_release[1]` is high for one cycle at edge 5 and `sw_press[1]` stays 0. Rebuild without the macro: `sw_release` stays 4'h0 throughout.
- Simultaneous channels: `SW3` press and `SW4` release arrive on the same edge. `sw_press[2]` and `sw_release[3]` assert in the same cycle.
- Reset mid-settle: assert `rst_n`=0 two cycles after a press starts. Outputs stay 0. After release, the settle restarts from 0, with full latency 5.

Source files
------------

// File: rtl/sw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sw_pkg
// Purpose  : Shared constants and types for the switch debouncer and the lock.
// Revision : 1.0 - initial release
// ============================================================================
package sw_pkg;

  localparam int SW_N              = 4;
  localparam int SW_CNT_W          = 16;
  localparam int SW_SETTLE_DEFAULT = 12000;

  localparam int SW1_IDX = 0;
  localparam int SW2_IDX = 1;
  localparam int SW3_IDX = 2;
  localparam int SW4_IDX = 3;

  typedef enum logic {
    SW_STABLE   = 1'b0,
    SW_SETTLING = 1'b1
  } sw_state_e;

endpackage : sw_pkg
`default_nettype wire

// File: rtl/sw_debounce_chan.sv
`default_nettype none
// ============================================================================
// Module   : sw_debounce_chan
// Purpose  : One switch channel: 2-flop synchroniser, settle counter, level and
//            press/release strobes. Release strobe built only with
//            SW_DEBOUNCE_RELEASE_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
module sw_debounce_chan
  import sw_pkg::*;
#(
  parameter int CNT_W  = SW_CNT_W,
  parameter int SETTLE = SW_SETTLE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  logic             s1_q;
  logic             s2_q;
  logic             level_q;
  logic             level_d;
  logic             press_q;
  logic             press_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             cnt_done;
  sw_state_e        state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  always_comb begin
    state    = (s2_q == level_q) ? SW_STABLE : SW_SETTLING;
    cnt_done = (cnt_q == CNT_LAST);
  end

  // A mismatch that disappears before the count completes clears the counter.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    case (state)
      SW_STABLE: cnt_d = '0;
      SW_SETTLING: begin
        if (cnt_done) begin
          level_d = s2_q;
          press_d = s2_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: cnt_d = '0;
    endcase
  end

`ifdef SW_DEBOUNCE_RELEASE_EN
  logic release_q;
  logic release_d;

  always_comb begin
    release_d = (state == SW_SETTLING) && cnt_done && !s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      release_q <= 1'b0;
    end else begin
      release_q <= release_d;
    end
  end

  assign release_o = release_q;
`else
  assign release_o = 1'b0;
`endif

  assign level_o = level_q;
  assign press_o = press_q;

endmodule : sw_debounce_chan
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sw_debounce
// Purpose  : N_SW-channel switch synchroniser/debouncer with press/release
//            strobes. Define SW_DEBOUNCE_RELEASE_EN to build release strobes.
// Revision : 1.0 - initial release
// ============================================================================
module sw_debounce
  import sw_pkg::*;
#(
  parameter int N_SW   = SW_N,
  parameter int CNT_W  = SW_CNT_W,
  parameter int SETTLE = SW_SETTLE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_level,
  output logic [N_SW-1:0] sw_press,
  output logic [N_SW-1:0] sw_release
);

  genvar i;
  generate
    for (i = 0; i < N_SW; i++) begin : g_chan
      sw_debounce_chan #(
        .CNT_W  (CNT_W),
        .SETTLE (SETTLE)
      ) u_chan (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw_i     (sw_raw[i]),
        .level_o   (sw_level[i]),
        .press_o   (sw_press[i]),
        .release_o (sw_release[i])
      );
    end
  endgenerate

endmodule : sw_debounce
`default_nettype wire

// File: tb/tb_sw_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_sw_debounce
// Purpose  : Self-checking bench for sw_debounce with SETTLE=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sw_debounce;

  localparam int SETTLE = 4;
`ifdef SW_DEBOUNCE_RELEASE_EN
  localparam logic [3:0] REL_MASK = 4'hF;
`else
  localparam logic [3:0] REL_MASK = 4'h0;
`endif
  localparam logic [7:0] WIN = 8'((1 << SETTLE) - 1);

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw_raw;
  logic [3:0] sw_level;
  logic [3:0] sw_press;
  logic [3:0] sw_release;

  int n_vec = 0;
  int n_err = 0;
  int hold [4];

  always #5 clk = ~clk;

  sw_debounce #(
    .N_SW   (4),
    .CNT_W  (16),
    .SETTLE (SETTLE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_raw     (sw_raw),
    .sw_level   (sw_level),
    .sw_press   (sw_press),
    .sw_release (sw_release)
  );

  // Reference: a level flips once the last SETTLE synchronised samples all
  // disagree with it; synchronised sample = raw seen two edges earlier.
  typedef struct packed {
    logic [3:0]  d1;
    logic [3:0]  d2;
    logic [3:0]  lvl;
    logic [3:0]  pr;
    logic [3:0]  rl;
    logic [31:0] hist;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_next(input mstate_t s, input logic [3:0] raw);
    mstate_t    n = s;
    logic [7:0] h;
    for (int c = 0; c < 4; c++) begin
      h = {s.hist[c*8 +: 7], s.d2[c]};
      n.hist[c*8 +: 8] = h;
      n.pr[c] = 1'b0;
      n.rl[c] = 1'b0;
      if ((h & WIN) == (s.lvl[c] ? 8'h00 : WIN)) begin
        n.lvl[c] = ~s.lvl[c];
        n.pr[c]  = ~s.lvl[c];
        n.rl[c]  = s.lvl[c];
      end
    end
    n.d2 = s.d1;
    n.d1 = raw;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= model_next(m, sw_raw);
  end

  typedef struct {
    logic       rst;
    logic [3:0] raw;
    logic [3:0] lv;
    logic [3:0] pr;
    logic [3:0] rl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [3:0] raw, input logic [3:0] lv,
                     input logic [3:0] pr, input logic [3:0] rl);
    vec_t v;
    v.rst = rst; v.raw = raw; v.lv = lv; v.pr = pr; v.rl = rl;
    vecs.push_back(v);
  endtask

  task automatic addn(input int n, input logic rst, input logic [3:0] raw, input logic [3:0] lv);
    repeat (n) add(rst, raw, lv, 4'h0, 4'h0);
  endtask

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: level/press/release got %03h expected %03h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] dut_out();
    return {sw_level, sw_press, sw_release};
  endfunction

  function automatic logic [11:0] mdl_out();
    return {m.lvl, m.pr, m.rl & REL_MASK};
  endfunction

  initial begin
    logic [3:0]  r;
    logic [11:0] e;
    rst_n  = 1'b0;
    sw_raw = 4'h0;

    // reset with all switches held high
    add(1, 4'hF, 4'h0, 4'h0, 4'h0); addn(5, 0, 4'hF, 4'h0);
    add(0, 4'hF, 4'hF, 4'hF, 4'h0); add(0, 4'hF, 4'hF, 4'h0, 4'h0);
    // clean press on SW1
    add(1, 4'h0, 4'h0, 4'h0, 4'h0); add(0, 4'h0, 4'h0, 4'h0, 4'h0);
    addn(5, 0, 4'h1, 4'h0); add(0, 4'h1, 4'h1, 4'h1, 4'h0); addn(2, 0, 4'h1, 4'h1);
    // SW3 bounce 1,0,1,0 then a 3-cycle pulse, SW1 held
    add(0, 4'h5, 4'h1, 4'h0, 4'h0); add(0, 4'h1, 4'h1, 4'h0, 4'h0);
    add(0, 4'h5, 4'h1, 4'h0, 4'h0); add(0, 4'h1, 4'h1, 4'h0, 4'h0);
    addn(4, 0, 4'h1, 4'h1); addn(3, 0, 4'h5, 4'h1); addn(5, 0, 4'h1, 4'h1);
    // release on SW2
    add(1, 4'h2, 4'h0, 4'h0, 4'h0); addn(5, 0, 4'h2, 4'h0);
    add(0, 4'h2, 4'h2, 4'h2, 4'h0); add(0, 4'h2, 4'h2, 4'h0, 4'h0);
    addn(5, 0, 4'h0, 4'h2); add(0, 4'h0, 4'h0, 4'h0, 4'h2); add(0, 4'h0, 4'h0, 4'h0, 4'h0);
    // SW4 press, then SW3 press and SW4 release on the same edge
    addn(5, 0, 4'h8, 4'h0); add(0, 4'h8, 4'h8, 4'h8, 4'h0); add(0, 4'h8, 4'h8, 4'h0, 4'h0);
    addn(5, 0, 4'h4, 4'h8); add(0, 4'h4, 4'h4, 4'h4, 4'h8); add(0, 4'h4, 4'h4, 4'h0, 4'h0);
    // reset two cycles into a settle, then full latency again
    add(1, 4'h0, 4'h0, 4'h0, 4'h0); addn(2, 0, 4'h1, 4'h0); add(1, 4'h1, 4'h0, 4'h0, 4'h0);
    addn(5, 0, 4'h1, 4'h0); add(0, 4'h1, 4'h1, 4'h1, 4'h0); add(0, 4'h1, 4'h1, 4'h0, 4'h0);

    @(negedge clk);
    foreach (vecs[k]) begin
      rst_n  = ~vecs[k].rst;
      sw_raw = vecs[k].raw;
      @(negedge clk);
      check($sformatf("vec%0d", k), dut_out(), {vecs[k].lv, vecs[k].pr, vecs[k].rl & REL_MASK});
      check($sformatf("mdl%0d", k), dut_out(), mdl_out());
    end

    // asynchronous reset clears outputs without a clock edge
    sw_raw = 4'h1;
    repeat (3) @(negedge clk);
    check("held_level", dut_out(), 12'h100);
    #1 rst_n = 1'b0;
    #1 check("async_rst", dut_out(), 12'h000);
    @(negedge clk);
    rst_n  = 1'b1;
    sw_raw = 4'h0;
    repeat (3) @(negedge clk);

    // SW4 pulse of exactly SETTLE cycles is accepted, then released
    for (int k = 0; k < 14; k++) begin
      sw_raw = (k < 4) ? 4'h8 : 4'h0;
      @(negedge clk);
      e = 12'h000;
      if (k >= 5 && k <= 8) e[11:8] = 4'h8;
      if (k == 5)           e[7:4]  = 4'h8;
      if (k == 9)           e[3:0]  = 4'h8 & REL_MASK;
      check($sformatf("pulse4_%0d", k), dut_out(), e);
    end

    // randomized hold times against the reference model
    for (int c = 0; c < 4; c++) hold[c] = 0;
    r = 4'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check($sformatf("rand%0d", cyc), dut_out(), mdl_out());
      for (int c = 0; c < 4; c++) begin
        if (hold[c] == 0) begin
          r[c]    = 1'($urandom_range(0, 1));
          hold[c] = int'($urandom_range(1, 7));
        end else begin
          hold[c] = hold[c] - 1;
        end
      end
      sw_raw = r;
      rst_n  = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    check("rand_final", dut_out(), mdl_out());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_sw_debounce
`default_nettype wire
